mac_tx_arbiter: RTL

//  Two-requester frame scheduler. It merges two (ptr FIFO, data FIFO) frame sources into one
//  (ptr, data) sink FIFO pair that feeds the MAC TX path, e.g. the loopback stream plus a CPU

---
 rtl/mac_tx_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mac_tx_arbiter.sv
// Round-robin whole-frame scheduler merging two (ptr, data) FIFO sources into one sink pair.
// Frames with error flags or an illegal length are drained from the source and counted as drops.
module mac_tx_arbiter #(
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             src0_ptr_empty,
   output logic             src0_ptr_rd,
   input  logic [15:0]      src0_ptr_din,
   output logic             src0_data_rd,
   input  logic [7:0]       src0_data_din,
   input  logic             src1_ptr_empty,
   output logic             src1_ptr_rd,
   input  logic [15:0]      src1_ptr_din,
   output logic             src1_data_rd,
   input  logic [7:0]       src1_data_din,
   input  logic             sink_bp,
   output logic             sink_data_wr,
   output logic [7:0]       sink_data,
   output logic             sink_ptr_wr,
   output logic [15:0]      sink_ptr,
   output logic [CNT_W-1:0] drop_cnt0,
   output logic [CNT_W-1:0] drop_cnt1
);

   typedef enum logic [2:0] {IDLE, PWAIT, PLAT, DATA, TAIL} state_t;

   localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

   state_t      state;
   logic        grant;
   logic        last_grant;
   logic        next_grant;
   logic        any_req;
   logic        drop;
   logic        rd_d1;
   logic [10:0] len;
   logic [10:0] cnt;
   logic [1:0]  ptr_flags;
   logic [10:0] ptr_len;
   logic        ptr_drop;
   logic        unused_ptr_bits;

   // Pointer bits [13:11] carry no meaning for scheduling.
   assign unused_ptr_bits = ^{src0_ptr_din[13:11], src1_ptr_din[13:11]};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      any_req    = !src0_ptr_empty || !src1_ptr_empty;
      next_grant = (!src0_ptr_empty && !src1_ptr_empty) ? ~last_grant : src0_ptr_empty;
      ptr_flags  = grant ? src1_ptr_din[15:14] : src0_ptr_din[15:14];
      ptr_len    = grant ? src1_ptr_din[10:0]  : src0_ptr_din[10:0];
      ptr_drop   = (ptr_flags != 2'b00) || (ptr_len == 11'd0) || (ptr_len > MAX_LEN_L);
   end

   // Frame FSM plus data path; every byte lands on the sink one cycle after it appears on din.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         grant        <= 1'b0;
         last_grant   <= 1'b1;
         drop         <= 1'b0;
         rd_d1        <= 1'b0;
         len          <= '0;
         cnt          <= '0;
         src0_ptr_rd  <= 1'b0;
         src1_ptr_rd  <= 1'b0;
         src0_data_rd <= 1'b0;
         src1_data_rd <= 1'b0;
         sink_data_wr <= 1'b0;
         sink_data    <= '0;
         sink_ptr_wr  <= 1'b0;
         sink_ptr     <= '0;
         drop_cnt0    <= '0;
         drop_cnt1    <= '0;
      end else begin
         src0_ptr_rd  <= 1'b0;
         src1_ptr_rd  <= 1'b0;
         sink_ptr_wr  <= 1'b0;
         rd_d1        <= src0_data_rd | src1_data_rd;
         sink_data    <= grant ? src1_data_din : src0_data_din;
         sink_data_wr <= rd_d1 & ~drop;
         case (state)
            IDLE: begin
               if (!sink_bp && any_req) begin
                  grant      <= next_grant;
                  last_grant <= next_grant;
                  if (next_grant) src1_ptr_rd <= 1'b1;
                  else            src0_ptr_rd <= 1'b1;
                  state      <= PWAIT;
               end
            end
            PWAIT: state <= PLAT;
            PLAT: begin
               len  <= ptr_len;
               drop <= ptr_drop;
               if (ptr_len == 11'd0) begin
                  if (ptr_drop) begin
                     if (grant) drop_cnt1 <= sat_inc(drop_cnt1);
                     else       drop_cnt0 <= sat_inc(drop_cnt0);
                  end
                  state <= IDLE;
               end else begin
                  cnt <= ptr_len;
                  if (grant) src1_data_rd <= 1'b1;
                  else       src0_data_rd <= 1'b1;
                  state <= DATA;
               end
            end
            DATA: begin
               if (cnt > 11'd1) begin
                  cnt <= cnt - 11'd1;
               end else begin
                  src0_data_rd <= 1'b0;
                  src1_data_rd <= 1'b0;
                  state        <= TAIL;
               end
            end
            TAIL: begin
               if (!drop) begin
                  sink_ptr_wr <= 1'b1;
                  sink_ptr    <= {5'b0, len};
               end else if (grant) begin
                  drop_cnt1 <= sat_inc(drop_cnt1);
               end else begin
                  drop_cnt0 <= sat_inc(drop_cnt0);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
